// File: rtl/dro_pkg.sv
// Shared types and constant helpers for the DRO/NDRO storage-cell array model.
package dro_pkg;

  typedef enum logic {
    MODE_DRO  = 1'b0,
    MODE_NDRO = 1'b1
  } dro_mode_e;

  // Bits needed to index v distinct values (minimum 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Trackers count up to max(setup, hold) and then hold there.
  function automatic int trk_width(input int setup_cyc, input int hold_cyc);
    int m;
    m = (setup_cyc > hold_cyc) ? setup_cyc : hold_cyc;
    return clog2(m + 1);
  endfunction

  localparam int EV_W = 2;

endpackage

// File: rtl/dro_array_sync_cell.sv
// One DRO/NDRO storage channel: stored bit, separation trackers, readout pulse,
// sticky timing-violation flags and the number of violation events this edge.
module dro_cell
  import dro_pkg::*;
#(
  parameter int        SETUP_CYC = 3,
  parameter int        HOLD_CYC  = 2,
  parameter dro_mode_e MODE      = MODE_DRO
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set,
  input  logic            reset,
  input  logic            clear_viol,
  output logic            out,
  output logic            state,
  output logic            viol_setup,
  output logic            viol_hold,
  output logic [EV_W-1:0] events
);

  localparam int SAT = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int TW  = trk_width(SETUP_CYC, HOLD_CYC);
  localparam logic [TW-1:0] SAT_V = TW'(SAT);

  logic [TW-1:0] since_set_reg, since_set_next;
  logic [TW-1:0] since_reset_reg, since_reset_next;
  logic          state_reg, state_next;
  logic          out_reg, out_next;
  logic          setup_reg, setup_next;
  logic          hold_reg, hold_next;
  logic          setup_v, hold_v;

  // A strobe on the same edge as its opposite counts as separation 0.
  assign setup_v = reset && (set || (since_set_reg < TW'(SETUP_CYC)));
  assign hold_v  = (HOLD_CYC > 0) && set && (reset || (since_reset_reg < TW'(HOLD_CYC)));

  always_comb begin
    state_next = state_reg;
    out_next   = 1'b0;
    // Readout is resolved before a coincident write.
    if (reset) begin
      if (setup_v) begin
        state_next = 1'b0;
      end else begin
        out_next = state_reg;
        if (MODE == MODE_DRO) state_next = 1'b0;
      end
    end
    if (set) state_next = 1'b1;

    since_set_next   = set   ? TW'(1) : ((since_set_reg   == SAT_V) ? SAT_V : since_set_reg   + TW'(1));
    since_reset_next = reset ? TW'(1) : ((since_reset_reg == SAT_V) ? SAT_V : since_reset_reg + TW'(1));

    setup_next = (clear_viol ? 1'b0 : setup_reg) | setup_v;
    hold_next  = (clear_viol ? 1'b0 : hold_reg)  | hold_v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= 1'b0;
      out_reg         <= 1'b0;
      setup_reg       <= 1'b0;
      hold_reg        <= 1'b0;
      since_set_reg   <= SAT_V;
      since_reset_reg <= SAT_V;
    end else begin
      state_reg       <= state_next;
      out_reg         <= out_next;
      setup_reg       <= setup_next;
      hold_reg        <= hold_next;
      since_set_reg   <= since_set_next;
      since_reset_reg <= since_reset_next;
    end
  end

  assign out        = out_reg;
  assign state      = state_reg;
  assign viol_setup = setup_reg;
  assign viol_hold  = hold_reg;
  assign events     = EV_W'(setup_v) + EV_W'(hold_v);

endmodule

// File: rtl/dro_array_sync.sv
// Array of independent DRO/NDRO cells with a shared saturating violation counter
// and a one-cycle pulse following any edge that produced a violation.
module dro_array_sync
  import dro_pkg::*;
#(
  parameter int        CHANNELS  = 4,
  parameter int        SETUP_CYC = 3,
  parameter int        HOLD_CYC  = 2,
  parameter dro_mode_e MODE      = MODE_DRO,
  parameter int        VCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] set,
  input  logic [CHANNELS-1:0] reset,
  input  logic                clear_viol,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] state,
  output logic [CHANNELS-1:0] viol_setup,
  output logic [CHANNELS-1:0] viol_hold,
  output logic                viol_pulse,
  output logic [VCNT_W-1:0]   viol_count
);

  localparam int SUM_W = clog2(2 * CHANNELS + 1);
  localparam int ACC_W = VCNT_W + SUM_W;
  localparam logic [VCNT_W-1:0] CNT_MAX = '1;

  logic [EV_W-1:0]   events [CHANNELS];
  logic [SUM_W-1:0]  ev_sum;
  logic [ACC_W-1:0]  acc;
  logic [VCNT_W-1:0] count_reg, count_next;
  logic              pulse_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cell
    dro_cell #(
      .SETUP_CYC(SETUP_CYC),
      .HOLD_CYC (HOLD_CYC),
      .MODE     (MODE)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .set       (set[gi]),
      .reset     (reset[gi]),
      .clear_viol(clear_viol),
      .out       (out[gi]),
      .state     (state[gi]),
      .viol_setup(viol_setup[gi]),
      .viol_hold (viol_hold[gi]),
      .events    (events[gi])
    );
  end

  always_comb begin
    ev_sum = '0;
    for (int i = 0; i < CHANNELS; i++) ev_sum = ev_sum + SUM_W'(events[i]);
    // A clear on a violating edge leaves exactly this edge's events in the count.
    acc = ACC_W'(clear_viol ? '0 : count_reg) + ACC_W'(ev_sum);
    count_next = (acc > ACC_W'(CNT_MAX)) ? CNT_MAX : acc[VCNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
      pulse_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      pulse_reg <= (ev_sum != '0);
    end
  end

  assign viol_count = count_reg;
  assign viol_pulse = pulse_reg;

endmodule

// File: tb/tb_dro_array_sync.sv
// Bench for dro_array_sync: DRO and NDRO instances share stimulus and are checked
// against an edge-index based reference model of the cell timing rules.
module tb_dro_array_sync;
  import dro_pkg::*;

  localparam int CH = 4;
  localparam int SETUP = 3;
  localparam int HOLD = 2;
  localparam int VW = 8;
  localparam int CMAX = (1 << VW) - 1;
  localparam int NEVER = -100000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] set_i = '0;
  logic [CH-1:0] reset_i = '0;
  logic          clear_i = 1'b0;

  logic [CH-1:0] out_d, state_d, vs_d, vh_d, out_n, state_n, vs_n, vh_n;
  logic          vp_d, vp_n;
  logic [VW-1:0] vc_d, vc_n;

  always #5 clk = ~clk;

  dro_array_sync #(.CHANNELS(CH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .MODE(MODE_DRO), .VCNT_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i), .clear_viol(clear_i),
    .out(out_d), .state(state_d), .viol_setup(vs_d), .viol_hold(vh_d),
    .viol_pulse(vp_d), .viol_count(vc_d));

  dro_array_sync #(.CHANNELS(CH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .MODE(MODE_NDRO), .VCNT_W(VW)) dut_n (
    .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i), .clear_viol(clear_i),
    .out(out_n), .state(state_n), .viol_setup(vs_n), .viol_hold(vh_n),
    .viol_pulse(vp_n), .viol_count(vc_n));

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Reference model: edge numbers of last strobes, stored bits per mode (0=DRO, 1=NDRO).
  int   last_set [CH];
  int   last_rst [CH];
  bit   m_state [2][CH];
  bit   m_out [2][CH];
  bit   m_vs [CH];
  bit   m_vh [CH];
  int   m_count = 0;
  bit   m_pulse = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_no, got, exp);
    end
  endtask

  function automatic logic [CH-1:0] pack(input bit v [CH]);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_edge(input logic [CH-1:0] s, input logic [CH-1:0] r, input logic clr, input logic rn);
    int ev;
    ev = 0;
    for (int i = 0; i < CH; i++) begin
      if (!rn) begin
        last_set[i] = NEVER;
        last_rst[i] = NEVER;
        m_vs[i] = 0;
        m_vh[i] = 0;
        for (int m = 0; m < 2; m++) begin
          m_state[m][i] = 0;
          m_out[m][i] = 0;
        end
      end else begin
        bit sv, hv;
        sv = 0;
        hv = 0;
        for (int m = 0; m < 2; m++) m_out[m][i] = 0;
        if (r[i]) begin
          int ds;
          ds = s[i] ? 0 : edge_no - last_set[i];
          if (ds < SETUP) begin
            sv = 1;
            for (int m = 0; m < 2; m++) m_state[m][i] = 0;
          end else begin
            for (int m = 0; m < 2; m++) m_out[m][i] = m_state[m][i];
            m_state[0][i] = 0;
          end
        end
        if (s[i]) begin
          int dr;
          dr = r[i] ? 0 : edge_no - last_rst[i];
          if (HOLD > 0 && dr < HOLD) hv = 1;
          for (int m = 0; m < 2; m++) m_state[m][i] = 1;
        end
        if (s[i]) last_set[i] = edge_no;
        if (r[i]) last_rst[i] = edge_no;
        if (clr) begin
          m_vs[i] = 0;
          m_vh[i] = 0;
        end
        m_vs[i] = m_vs[i] | sv;
        m_vh[i] = m_vh[i] | hv;
        ev += int'(sv) + int'(hv);
      end
    end
    if (!rn) begin
      m_count = 0;
      m_pulse = 0;
    end else begin
      m_count = (clr ? 0 : m_count) + ev;
      if (m_count > CMAX) m_count = CMAX;
      m_pulse = (ev > 0);
    end
  endtask

  task automatic step(input logic [CH-1:0] s, input logic [CH-1:0] r, input logic clr, input logic rn);
    set_i = s;
    reset_i = r;
    clear_i = clr;
    rst_n = rn;
    model_edge(s, r, clr, rn);
    @(posedge clk);
    #1;
    check("out_dro",    32'(out_d),   32'(pack(m_out[0])));
    check("state_dro",  32'(state_d), 32'(pack(m_state[0])));
    check("out_ndro",   32'(out_n),   32'(pack(m_out[1])));
    check("state_ndro", 32'(state_n), 32'(pack(m_state[1])));
    check("viol_setup", 32'(vs_d),    32'(pack(m_vs)));
    check("viol_hold",  32'(vh_d),    32'(pack(m_vh)));
    check("viol_pulse", 32'(vp_d),    32'(m_pulse));
    check("viol_count", 32'(vc_d),    32'(m_count));
    check("flags_ndro", 32'({vs_n, vh_n, vp_n}), 32'({pack(m_vs), pack(m_vh), m_pulse}));
    check("count_ndro", 32'(vc_n),    32'(m_count));
    $display("edge %0d rn=%b set=%b rst=%b clr=%b | out=%b/%b state=%b/%b vs=%b vh=%b vp=%b vc=%0d",
             edge_no, rn, s, r, clr, out_d, out_n, state_d, state_n, vs_d, vh_d, vp_d, vc_d);
    edge_no++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      last_set[i] = NEVER;
      last_rst[i] = NEVER;
    end
    @(negedge clk);
    step('0, '0, 1'b0, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);   // strobes ignored under reset
    idle(3);
    // clean readout
    step(4'b0001, '0, 1'b0, 1'b1);
    idle(9);
    step('0, 4'b0001, 1'b0, 1'b1);
    idle(2);
    // setup boundary: d=2 violates, d=3 is clean
    step(4'b0010, '0, 1'b0, 1'b1);
    idle(1);
    step('0, 4'b0010, 1'b0, 1'b1);
    idle(5);
    step(4'b0010, '0, 1'b0, 1'b1);
    idle(2);
    step('0, 4'b0010, 1'b0, 1'b1);
    idle(2);
    // repeated readout (NDRO instance keeps the bit)
    step(4'b0100, '0, 1'b0, 1'b1);
    idle(5);
    step('0, 4'b0100, 1'b0, 1'b1);
    idle(9);
    step('0, 4'b0100, 1'b0, 1'b1);
    idle(2);
    // simultaneous set/reset, then reset followed by set one edge later
    step(4'b1000, 4'b1000, 1'b0, 1'b1);
    idle(5);
    step('0, 4'b1000, 1'b0, 1'b1);
    step(4'b1000, '0, 1'b0, 1'b1);
    idle(1);
    step('0, '0, 1'b1, 1'b1);
    // reset with all cells stored, then immediate readout
    step(4'b1111, '0, 1'b0, 1'b1);
    idle(3);
    step('0, '0, 1'b0, 1'b0);
    step('0, 4'b1111, 1'b0, 1'b1);
    idle(2);
    // clear on a violating edge
    step(4'b0001, '0, 1'b0, 1'b1);
    step('0, 4'b0001, 1'b1, 1'b1);
    idle(1);
    // counter saturation: 8 events per edge
    for (int k = 0; k < 40; k++) step(4'b1111, 4'b1111, 1'b0, 1'b1);
    idle(2);
    step('0, '0, 1'b1, 1'b1);
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [CH-1:0] s, r;
      s = CH'($urandom_range(0, 15) & $urandom_range(0, 15));
      r = CH'($urandom_range(0, 15) & $urandom_range(0, 15));
      step(s, r, ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) != 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
